frame_burst_writer: RTL and testbench
=====================================

# frame_burst_writer

Downstream consumer of the demosaic frame wrapper. Accepts its 64-bit output stream (2 pixels/beat, 153600 beats per 640x480 frame) through a valid/ready port and buffers it in an internal FWFT FIFO. Emits fixed-length address+data bursts to the DRAM write port, one frame at a time, with a per-frame done pulse and a completed-frame counter.

## Interface
- DATA_W, 64, beat width in bits (8 bytes/beat)
- BURST_LEN, 16, beats per burst; power of 2, 2..64
- FIFO_DEPTH, 32, FIFO entries; power of 2, >= 2*BURST_LEN
- FRAME_BEATS, 153600, beats per frame; must be a multiple of BURST_LEN
- BASE_ADDR, 32'h3000_0000, byte address of frame buffer 0
- clk  in  1  sole clock
- reset  in  1  synchronous, active-high
- start  in  1  leaves IDLE; ignored in other states
- in_valid  in  1  upstream beat valid
- in_ready  out  1  FIFO can accept a beat
- in_data  in  DATA_W  upstream beat
- wr_addr_valid  out  1  burst address valid
- wr_addr_ready  in  1  address accepted
- wr_addr  out  32  burst byte address
- wr_len  out  8  BURST_LEN-1, constant
- wr_data_valid  out  1  write beat valid
- wr_data_ready  in  1  write beat accepted
- wr_data  out  DATA_W  FIFO head
- wr_last  out  1  final beat of burst
- frame_done  out  1  one-cycle pulse, frame fully written
- frames_written  out  16  completed frame count, wraps
- busy  out  1  state != IDLE

## Operation
- One clock; reset is synchronous and active-high (clk, reset).
- FIFO: in_ready = (count != FIFO_DEPTH). Push on in_valid&&in_ready; pop on wr_data_valid&&wr_data_ready. Simultaneous push+pop leaves count unchanged, legal even when full or empty (pop only if count>0). count width log2(FIFO_DEPTH)+1.
- States: IDLE, WAIT, ADDR, DATA.
- IDLE: start -> WAIT. FIFO accepts beats in all states, including IDLE.
- WAIT: count >= BURST_LEN -> ADDR.
- ADDR: wr_addr_valid=1, wr_addr = frame_base + burst_idx*BURST_LEN*8. Held stable until wr_addr_ready; then -> DATA, beat_cnt=0.
- DATA: wr_data_valid = (count>0); wr_last = (beat_cnt==BURST_LEN-1). On each accepted beat beat_cnt++. On accepted last beat: if burst_idx == FRAME_BEATS/BURST_LEN-1 then burst_idx=0, frame_done=1 next cycle, frames_written+=1, frame_base updated (see Configuration); else burst_idx++. Either way -> WAIT.
- wr_addr_valid and wr_data_valid never high together.
- Address arithmetic: 32-bit, modulo 2^32; burst_idx 32-bit.

## Timing
- Reset values: in_ready=1, wr_addr_valid=0, wr_addr=BASE_ADDR, wr_data_valid=0, wr_last=0, frame_done=0, frames_written=0, busy=0; FIFO empty, burst_idx=0, frame_base=BASE_ADDR, state IDLE.
- reset mid-burst: all of the above next cycle; buffered beats discarded, partial burst abandoned.
- FIFO data latency: beat pushed in cycle N is visible at wr_data in cycle N+1 if FIFO was empty.
- WAIT->ADDR: ADDR asserted the cycle after count first reaches BURST_LEN.
- Best case per burst: 1 ADDR cycle + BURST_LEN DATA cycles + 1 WAIT cycle.
- frame_done is registered: high exactly one cycle, the cycle after the last beat of the frame is accepted; frames_written updates in that same cycle. 16'hFFFF wraps to 0.
- wr_data/wr_last stable while wr_data_valid && !wr_data_ready.

## Configuration
- FBW_DOUBLE_BUFFER_EN defined: frame_base toggles between BASE_ADDR and BASE_ADDR + FRAME_BEATS*8 after each completed frame (frame 0 at buffer 0, frame 1 at buffer 1, ...).
- Undefined: frame_base is always BASE_ADDR; every frame overwrites the same buffer.

## Test plan
- Reset then start, stream 16 beats 0..15 with ready always high -> one ADDR at 32'h3000_0000, wr_len=15, 16 data beats 0..15, wr_last only on beat 15.
- Full frame (153600 beats), sinks always ready -> 9600 bursts, final wr_addr 32'h3012_BF80, single frame_done pulse, frames_written=1.
- Two frames with FBW_DOUBLE_BUFFER_EN -> frame 2 first burst at 32'h3012_C000; without macro at 32'h3000_0000; frames_written=2.
- wr_data_ready held low with 40 beats offered -> in_ready drops after 32 accepted; release -> no beat lost or duplicated, order preserved.
- wr_addr_ready delayed 5 cycles -> wr_addr_valid and wr_addr stable for 6 cycles, no data beat issued meanwhile.
- reset asserted mid-burst at beat 7 -> next cycle all outputs at reset values, busy=0; following start restarts at BASE_ADDR.

Source files
------------

// File: rtl/frame_burst_writer.sv
// Buffers a 2-pixel/beat frame stream in a FWFT FIFO and writes it out as fixed-length DRAM bursts.
// Optional FBW_DOUBLE_BUFFER_EN: alternate frames between two frame buffers.
module frame_burst_writer #(
  parameter int unsigned DATA_W      = 64,
  parameter int unsigned BURST_LEN   = 16,
  parameter int unsigned FIFO_DEPTH  = 32,
  parameter int unsigned FRAME_BEATS = 153600,
  parameter logic [31:0] BASE_ADDR   = 32'h3000_0000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              wr_addr_valid,
  input  logic              wr_addr_ready,
  output logic [31:0]       wr_addr,
  output logic [7:0]        wr_len,
  output logic              wr_data_valid,
  input  logic              wr_data_ready,
  output logic [DATA_W-1:0] wr_data,
  output logic              wr_last,
  output logic              frame_done,
  output logic [15:0]       frames_written,
  output logic              busy
);

  localparam int unsigned AW          = $clog2(FIFO_DEPTH);
  localparam int unsigned CW          = AW + 1;
  localparam int unsigned BW          = $clog2(BURST_LEN);
  localparam int unsigned NUM_BURSTS  = FRAME_BEATS / BURST_LEN;
  localparam logic [31:0] BURST_BYTES = 32'(BURST_LEN * 8);
  localparam logic [31:0] FRAME_BYTES = 32'(FRAME_BEATS * 8);
  localparam logic [31:0] LAST_BURST  = 32'(NUM_BURSTS - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ADDR, S_DATA} state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]     wptr_q, rptr_q;
  logic [CW-1:0]     count_q;
  logic [BW-1:0]     beat_cnt_q, beat_cnt_d;
  logic [31:0]       burst_idx_q, burst_idx_d;
  logic [31:0]       frame_base_q, frame_base_d;
  logic [31:0]       next_frame_base;
  logic [15:0]       frames_written_q, frames_written_d;
  logic              frame_done_q, frame_done_d;
  logic              push, pop;

  // FIFO storage and occupancy
  assign in_ready = (count_q != CW'(FIFO_DEPTH));
  assign push     = in_valid && in_ready;
  assign pop      = wr_data_valid && wr_data_ready;
  assign wr_data  = mem_q[rptr_q];

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= in_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + AW'(1);
      if (pop)  rptr_q <= rptr_q + AW'(1);
      if (push && !pop)      count_q <= count_q + CW'(1);
      else if (pop && !push) count_q <= count_q - CW'(1);
    end
  end

`ifdef FBW_DOUBLE_BUFFER_EN
  assign next_frame_base = (frame_base_q == BASE_ADDR) ? BASE_ADDR + FRAME_BYTES : BASE_ADDR;
`else
  assign next_frame_base = BASE_ADDR;
`endif

  assign wr_addr        = frame_base_q + burst_idx_q * BURST_BYTES;
  assign wr_len         = 8'(BURST_LEN - 1);
  assign frame_done     = frame_done_q;
  assign frames_written = frames_written_q;
  assign busy           = (state_q != S_IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= S_IDLE;
      beat_cnt_q       <= '0;
      burst_idx_q      <= '0;
      frame_base_q     <= BASE_ADDR;
      frames_written_q <= '0;
      frame_done_q     <= 1'b0;
    end else begin
      state_q          <= state_d;
      beat_cnt_q       <= beat_cnt_d;
      burst_idx_q      <= burst_idx_d;
      frame_base_q     <= frame_base_d;
      frames_written_q <= frames_written_d;
      frame_done_q     <= frame_done_d;
    end
  end

  // Burst sequencing: wait for a full burst in the FIFO, issue address, stream data
  always_comb begin
    state_d          = state_q;
    beat_cnt_d       = beat_cnt_q;
    burst_idx_d      = burst_idx_q;
    frame_base_d     = frame_base_q;
    frames_written_d = frames_written_q;
    frame_done_d     = 1'b0;
    wr_addr_valid    = 1'b0;
    wr_data_valid    = 1'b0;
    wr_last          = 1'b0;
    case (state_q)
      S_IDLE: if (start) state_d = S_WAIT;
      S_WAIT: if (count_q >= CW'(BURST_LEN)) state_d = S_ADDR;
      S_ADDR: begin
        wr_addr_valid = 1'b1;
        if (wr_addr_ready) begin
          state_d    = S_DATA;
          beat_cnt_d = '0;
        end
      end
      S_DATA: begin
        wr_data_valid = (count_q != '0);
        wr_last       = (beat_cnt_q == BW'(BURST_LEN - 1));
        if (wr_data_valid && wr_data_ready) begin
          beat_cnt_d = beat_cnt_q + BW'(1);
          if (wr_last) begin
            state_d = S_WAIT;
            if (burst_idx_q == LAST_BURST) begin
              burst_idx_d      = '0;
              frame_done_d     = 1'b1;
              frames_written_d = frames_written_q + 16'd1;
              frame_base_d     = next_frame_base;
            end else begin
              burst_idx_d = burst_idx_q + 32'd1;
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_frame_burst_writer.sv
// Randomized and directed checks of frame_burst_writer against a queue-based reference model.
module tb_frame_burst_writer;

  localparam int unsigned DATA_W = 64;
  localparam int unsigned BL     = 16;
  localparam int unsigned DEPTH  = 32;
  localparam int unsigned FB     = 64;
  localparam int unsigned NB     = FB / BL;
  localparam logic [31:0] BASE   = 32'h3000_0000;

  logic clk, reset, start, in_valid, in_ready, wr_addr_valid, wr_addr_ready;
  logic wr_data_valid, wr_data_ready, wr_last, frame_done, busy;
  logic [DATA_W-1:0] in_data, wr_data;
  logic [31:0] wr_addr;
  logic [7:0]  wr_len;
  logic [15:0] frames_written;

  frame_burst_writer #(.DATA_W(DATA_W), .BURST_LEN(BL), .FIFO_DEPTH(DEPTH),
                       .FRAME_BEATS(FB), .BASE_ADDR(BASE)) dut (
    .clk(clk), .reset(reset), .start(start),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .wr_addr_valid(wr_addr_valid), .wr_addr_ready(wr_addr_ready), .wr_addr(wr_addr), .wr_len(wr_len),
    .wr_data_valid(wr_data_valid), .wr_data_ready(wr_data_ready), .wr_data(wr_data), .wr_last(wr_last),
    .frame_done(frame_done), .frames_written(frames_written), .busy(busy));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  logic [DATA_W-1:0] q[$];
  int unsigned n_addr, bib, popped, pushed;
  bit          in_burst, started, done_exp;
  logic [15:0] fw_exp;
  logic [31:0] first_addr;
  int n_assert = 0;
  int n_fail   = 0;

  function automatic logic [31:0] exp_addr(input int unsigned n);
    int unsigned frame = n / NB;
    logic [31:0] base = BASE;
`ifdef FBW_DOUBLE_BUFFER_EN
    if (frame % 2 == 1) base = BASE + 32'(FB * 8);
`else
    if (frame > 0) base = BASE;
`endif
    return base + 32'((n % NB) * BL * 8);
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    n_addr = 0; bib = 0; popped = 0; in_burst = 0; started = 0;
    done_exp = 0; fw_exp = '0; first_addr = '0;
  endtask

  // One clock cycle: check outputs against the model, then advance the model by the observed handshakes
  task automatic tick();
    bit push, ahs, dhs;
    logic [DATA_W-1:0] pdata;
    logic [31:0] aval;
    bit done_next;
    #1;
    if (!reset) begin
      chk("in_ready", 64'(in_ready), 64'(q.size() != DEPTH));
      chk("valid_excl", 64'(wr_addr_valid && wr_data_valid), 64'd0);
      chk("busy", 64'(busy), 64'(started));
      chk("frame_done", 64'(frame_done), 64'(done_exp));
      chk("frames_written", 64'(frames_written), 64'(fw_exp));
      chk("data_valid", 64'(wr_data_valid), 64'(in_burst && q.size() > 0));
      if (q.size() > 0) chk("wr_data", wr_data, q[0]);
      if (wr_addr_valid) begin
        chk("wr_addr", 64'(wr_addr), 64'(exp_addr(n_addr)));
        chk("wr_len", 64'(wr_len), 64'(BL - 1));
        chk("addr_mid_burst", 64'(in_burst), 64'd0);
      end
      if (wr_data_valid) chk("wr_last", 64'(wr_last), 64'(bib == BL - 1));
    end
    push = in_valid && in_ready;
    ahs  = wr_addr_valid && wr_addr_ready;
    dhs  = wr_data_valid && wr_data_ready;
    pdata = in_data;
    aval  = wr_addr;
    @(posedge clk);
    if (reset) begin
      model_reset();
    end else begin
      done_next = 0;
      if (start) started = 1;
      if (ahs) begin
        if (n_addr == 0) first_addr = aval;
        n_addr++;
        in_burst = 1;
      end
      if (dhs && q.size() > 0) begin
        void'(q.pop_front());
        popped++;
        bib++;
        if (bib == BL) begin
          bib = 0;
          in_burst = 0;
        end
        if (popped % FB == 0) begin
          done_next = 1;
          fw_exp = fw_exp + 16'd1;
        end
      end
      if (push) begin
        q.push_back(pdata);
        pushed++;
      end
      done_exp = done_next;
    end
    @(negedge clk);
    if (push && !reset) in_data = {$urandom, $urandom};
  endtask

  task automatic drain();
    bit ok = 0;
    for (int i = 0; i < 3000; i++) begin
      if (q.size() == 0 && !in_burst) begin
        ok = 1;
        break;
      end
      tick();
    end
    chk("drain_timeout", 64'(ok), 64'd1);
  endtask

  task automatic push_n(input int unsigned n);
    in_valid = 1;
    for (int i = 0; i < int'(n); i++) tick();
    in_valid = 0;
  endtask

  initial begin
    int unsigned p0, hold;
    bit reached;
    reset = 1; start = 0; in_valid = 0; in_data = '0;
    wr_addr_ready = 1; wr_data_ready = 1; pushed = 0;
    model_reset();
    tick(); tick();
    reset = 0;
    tick();

    // First burst of beats 0..15 and WAIT->ADDR latency
    start = 1; tick(); start = 0;
    in_valid = 1;
    for (int k = 0; k < 16; k++) begin
      in_data = 64'(k);
      tick();
    end
    in_valid = 0;
    chk("wait_before_addr", 64'(wr_addr_valid), 64'd0);
    tick();
    chk("addr_after_count", 64'(wr_addr_valid), 64'd1);
    chk("first_wr_addr", 64'(wr_addr), 64'(BASE));
    drain();

    // Random traffic over three frames
    p0 = pushed;
    for (int i = 0; i < 5000 && pushed - p0 < 3 * FB; i++) begin
      in_valid      = ($urandom_range(0, 3) != 0);
      wr_addr_ready = ($urandom_range(0, 3) != 0);
      wr_data_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    in_valid = 0; wr_addr_ready = 1; wr_data_ready = 1;
    chk("random_pushed", 64'(pushed - p0), 64'(3 * FB));
    drain();

    // Data sink stalled: FIFO fills to depth, then drains in order
    wr_data_ready = 0;
    p0 = pushed;
    push_n(40);
    chk("bp_accepted", 64'(pushed - p0), 64'(DEPTH));
    chk("bp_in_ready", 64'(in_ready), 64'd0);
    wr_data_ready = 1;
    drain();

    // Address acceptance delayed by five cycles
    wr_addr_ready = 0;
    push_n(16);
    for (int i = 0; i < 10 && !wr_addr_valid; i++) tick();
    hold = 0;
    for (int i = 0; i < 5; i++) begin
      if (wr_addr_valid) hold++;
      tick();
    end
    wr_addr_ready = 1;
    if (wr_addr_valid) hold++;
    tick();
    chk("addr_hold_cycles", 64'(hold), 64'd6);
    chk("addr_released", 64'(wr_addr_valid), 64'd0);
    drain();

    // Reset in the middle of a burst, then restart
    push_n(16);
    reached = 0;
    for (int i = 0; i < 60; i++) begin
      if (in_burst && bib == 7 && wr_data_valid) begin
        reached = 1;
        break;
      end
      tick();
    end
    chk("reached_beat7", 64'(reached), 64'd1);
    reset = 1; tick(); reset = 0;
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_addr_valid", 64'(wr_addr_valid), 64'd0);
    chk("rst_wr_addr", 64'(wr_addr), 64'(BASE));
    chk("rst_data_valid", 64'(wr_data_valid), 64'd0);
    chk("rst_wr_last", 64'(wr_last), 64'd0);
    chk("rst_frame_done", 64'(frame_done), 64'd0);
    chk("rst_frames", 64'(frames_written), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    tick();
    start = 1; tick(); start = 0;
    push_n(16);
    drain();
    chk("restart_addr", 64'(first_addr), 64'(BASE));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
